// File: rtl/id_dispatch_queue.sv
// In-order decoded-instruction queue between ID/EX and rename/dispatch.
// First-word fall-through head, valid/ready on both sides, flush on redirect.
module id_dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode_in,
    input  logic [2:0]       funct3_in,
    input  logic [6:0]       funct7_in,
    input  logic [4:0]       srcReg1_in,
    input  logic [4:0]       srcReg2_in,
    input  logic [4:0]       destReg_in,
    input  logic [31:0]      imm_in,
    input  logic [1:0]       lwSw_in,
    input  logic             regWrite_in,
    input  logic             memRead_in,
    input  logic             memWrite_in,
    input  logic             memToReg_in,
    input  logic             hasImm_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode_out,
    output logic [2:0]       funct3_out,
    output logic [6:0]       funct7_out,
    output logic [4:0]       srcReg1_out,
    output logic [4:0]       srcReg2_out,
    output logic [4:0]       destReg_out,
    output logic [31:0]      imm_out,
    output logic [1:0]       lwSw_out,
    output logic             regWrite_out,
    output logic             memRead_out,
    output logic             memWrite_out,
    output logic             memToReg_out,
    output logic             hasImm_out,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  lw_sw;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        has_imm;
    } bundle_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    bundle_t          mem [DEPTH];
    bundle_t          in_b;
    bundle_t          head_b;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;
    logic [PTR_W:0]   cnt_next;
    logic             push;
    logic             pop;

    assign in_b = '{
        opcode:     opcode_in,
        funct3:     funct3_in,
        funct7:     funct7_in,
        rs1:        srcReg1_in,
        rs2:        srcReg2_in,
        rd:         destReg_in,
        imm:        imm_in,
        lw_sw:      lwSw_in,
        reg_write:  regWrite_in,
        mem_read:   memRead_in,
        mem_write:  memWrite_in,
        mem_to_reg: memToReg_in,
        has_imm:    hasImm_in
    };

    // Full blocks input even when dispatch pops this cycle: no pass-through.
    assign in_ready  = (cnt != CNT_FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    always_comb begin
        cnt_next = cnt;
        unique case ({push, pop})
            2'b10:   cnt_next = cnt + 1'b1;
            2'b01:   cnt_next = cnt - 1'b1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            cnt <= cnt_next;
        end
    end

    // Storage is not reset; the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= in_b;
    end

    assign head_b = out_valid ? mem[head] : '0;

    assign opcode_out   = head_b.opcode;
    assign funct3_out   = head_b.funct3;
    assign funct7_out   = head_b.funct7;
    assign srcReg1_out  = head_b.rs1;
    assign srcReg2_out  = head_b.rs2;
    assign destReg_out  = head_b.rd;
    assign imm_out      = head_b.imm;
    assign lwSw_out     = head_b.lw_sw;
    assign regWrite_out = head_b.reg_write;
    assign memRead_out  = head_b.mem_read;
    assign memWrite_out = head_b.mem_write;
    assign memToReg_out = head_b.mem_to_reg;
    assign hasImm_out   = head_b.has_imm;

endmodule

// File: tb/tb_id_dispatch_queue.sv
// Self-checking bench for id_dispatch_queue: directed plan steps followed
// by random traffic, all compared against a queue-based reference model.
module tb_id_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  ls;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        hi;
    } tb_bundle_t;

    logic clk = 0;
    logic rst, flush, in_valid, out_ready;
    logic in_ready, out_valid;
    logic [PTR_W:0] count;
    tb_bundle_t drv, obs;

    int total = 0;
    int passes = 0;
    tb_bundle_t model_q[$];

    always #5 clk = ~clk;

    id_dispatch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(drv.op), .funct3_in(drv.f3), .funct7_in(drv.f7),
        .srcReg1_in(drv.r1), .srcReg2_in(drv.r2), .destReg_in(drv.rd),
        .imm_in(drv.imm), .lwSw_in(drv.ls), .regWrite_in(drv.rw),
        .memRead_in(drv.mr), .memWrite_in(drv.mw),
        .memToReg_in(drv.m2r), .hasImm_in(drv.hi),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode_out(obs.op), .funct3_out(obs.f3), .funct7_out(obs.f7),
        .srcReg1_out(obs.r1), .srcReg2_out(obs.r2), .destReg_out(obs.rd),
        .imm_out(obs.imm), .lwSw_out(obs.ls), .regWrite_out(obs.rw),
        .memRead_out(obs.mr), .memWrite_out(obs.mw),
        .memToReg_out(obs.m2r), .hasImm_out(obs.hi),
        .count(count)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic tb_bundle_t mk(input logic [6:0] op,
                                      input logic [4:0] rd,
                                      input logic [31:0] imm);
        tb_bundle_t b;
        b = tb_bundle_t'({$urandom, $urandom, $urandom});
        b.op = op;
        b.rd = rd;
        b.imm = imm;
        return b;
    endfunction

    // One clock: check outputs against the model mid-cycle, then update it.
    task automatic step(input bit r, input bit f, input bit iv,
                        input bit ordy, input tb_bundle_t b);
        bit do_push, do_pop;
        tb_bundle_t exp_head;
        rst = r;
        flush = f;
        in_valid = iv;
        out_ready = ordy;
        drv = b;
        @(negedge clk);
        exp_head = (model_q.size() != 0) ? model_q[0] : '0;
        chk("count", 128'(count), 128'(model_q.size()));
        chk("out_valid", 128'(out_valid), 128'(model_q.size() != 0));
        chk("in_ready", 128'(in_ready), 128'(model_q.size() != DEPTH));
        chk("head", 128'(obs), 128'(exp_head));
        do_push = iv && (model_q.size() < DEPTH);
        do_pop = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(b);
        end
        #1;
    endtask

    initial begin
        tb_bundle_t b;
        int n;
        rst = 1;
        flush = 0;
        in_valid = 0;
        out_ready = 0;
        drv = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Single push, then pop
        step(0, 0, 1, 0, mk(7'h33, 5'd5, 32'd0));
        chk("single_valid", 128'(out_valid), 128'(1));
        chk("single_op", 128'(obs.op), 128'(7'h33));
        chk("single_rd", 128'(obs.rd), 128'(5'd5));
        chk("single_cnt", 128'(count), 128'(1));
        step(0, 0, 0, 1, '0);
        chk("single_pop_cnt", 128'(count), 128'(0));
        chk("single_pop_valid", 128'(out_valid), 128'(0));

        // Fill to full, reject a fifth push, drain in order
        for (int i = 1; i <= 4; i++)
            step(0, 0, 1, 0, mk(7'h13, 5'(i), 32'(i)));
        chk("full_cnt", 128'(count), 128'(4));
        chk("full_in_ready", 128'(in_ready), 128'(0));
        step(0, 0, 1, 0, mk(7'h13, 5'd9, 32'd9));
        chk("full_reject_cnt", 128'(count), 128'(4));
        for (int i = 1; i <= 4; i++) begin
            chk("drain_rd", 128'(obs.rd), 128'(i));
            step(0, 0, 0, 1, '0);
        end
        chk("drained_valid", 128'(out_valid), 128'(0));

        // Push+pop at count=2, then continuous traffic across the wrap
        step(0, 0, 1, 0, mk(7'h03, 5'd10, 32'hffff_fff0));
        step(0, 0, 1, 0, mk(7'h03, 5'd11, 32'h10));
        for (int i = 0; i < 10; i++) begin
            chk("stream_rd", 128'(obs.rd), 128'(10 + i));
            step(0, 0, 1, 1, mk(7'h23, 5'(12 + i), 32'(i)));
            chk("stream_cnt", 128'(count), 128'(2));
        end

        // Full with pop: pop happens, push rejected
        step(0, 0, 1, 0, mk(7'h37, 5'd22, 32'd1));
        step(0, 0, 1, 0, mk(7'h37, 5'd23, 32'd2));
        chk("fp_full", 128'(count), 128'(4));
        step(0, 0, 1, 1, mk(7'h37, 5'd30, 32'd3));
        chk("fp_cnt", 128'(count), 128'(3));
        chk("fp_in_ready", 128'(in_ready), 128'(1));

        // Flush with simultaneous push and pop
        step(0, 1, 1, 1, mk(7'h6f, 5'd31, 32'd4));
        chk("flush_cnt", 128'(count), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_out", 128'(obs), 128'(0));
        step(0, 0, 1, 0, mk(7'h67, 5'd7, 32'd77));
        chk("post_flush_cnt", 128'(count), 128'(1));
        chk("post_flush_rd", 128'(obs.rd), 128'(5'd7));

        // Reset mid-operation with a push offered
        b = mk(7'h03, 5'd8, 32'd8);
        b.mr = 1;
        b.mw = 1;
        step(0, 0, 1, 0, b);
        chk("pre_rst_cnt", 128'(count), 128'(2));
        step(1, 0, 1, 0, b);
        chk("mid_rst_cnt", 128'(count), 128'(0));
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_mr", 128'(obs.mr), 128'(0));
        chk("mid_rst_mw", 128'(obs.mw), 128'(0));

        // Random traffic
        n = 400;
        for (int i = 0; i < n; i++) begin
            b = tb_bundle_t'({$urandom, $urandom, $urandom});
            step(($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 25) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 b);
        end
        step(0, 0, 0, 0, '0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
